// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register-bank controller: default sizes,
// FSM state encodings and requester identifiers.
package reg_bank_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NREGS = 4;
    localparam int DEF_AW    = 2;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage : reg_bank_pkg

// File: rtl/reg_bank_ctrl_rr_arb2.sv
// Two-way round-robin arbiter. One-hot grant, combinational from req.
// A single last-grant flop picks the winner when both requesters are
// active. The flop only moves on an actual grant, so idle cycles and
// disabled cycles leave the priority untouched.
module rr_arb2
    import reg_bank_pkg::*;
(
    input  logic       clk,
    input  logic       clr_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Identity of the requester granted most recently. Reset value SRC_B
    // gives A priority on the first contested cycle.
    logic last_q;
    logic last_d;

    // Combinational grant: a lone requester wins, a tie goes to the
    // requester that was not granted last.
    always_comb begin
        gnt = 2'b00;
        if (en && clr_n) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_q == SRC_A) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Next pointer: follows the winner, holds when nothing is granted.
    always_comb begin
        last_d = last_q;
        if (gnt[0]) begin
            last_d = SRC_A;
        end else if (gnt[1]) begin
            last_d = SRC_B;
        end
    end

    // Last-grant register.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            last_q <= SRC_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule : rr_arb2

// File: rtl/reg_bank_ctrl.sv
// Register bank shared by two requesters. One read or write per cycle,
// picked by a round-robin arbiter, plus an on-demand clear sweep that
// zeroes one register per cycle while holding off both requesters.
//
// Handshake (A and B alike): a requester raises *_req with its fields and
// keeps them stable until *_gnt is seen high; the transfer takes place on
// the rising edge where req and gnt are both high. *_gnt is combinational
// and may be high only while the matching *_req is high. A read result
// appears on rdata with rvalid high for exactly one cycle, the cycle after
// its grant; rsrc names the requester it belongs to.
module reg_bank_ctrl
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             a_req,
    input  logic             a_we,
    input  logic [AW-1:0]    a_addr,
    input  logic [WIDTH-1:0] a_wdata,
    output logic             a_gnt,
    input  logic             b_req,
    input  logic             b_we,
    input  logic [AW-1:0]    b_addr,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             b_gnt,
    input  logic             clear_all,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             rsrc,
    output logic             busy,
    output logic             state_dbg
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_e           state_q;
    state_e           state_d;
    logic [AW-1:0]    idx_q;
    logic [AW-1:0]    idx_d;
    logic [WIDTH-1:0] bank_q [NREGS];
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;
    logic             rsrc_q;

    logic             arb_en;
    logic [1:0]       gnt;

    // Winner's transaction fields.
    logic             sel_src;
    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_wdata;
    logic             do_xfer;

    rr_arb2 u_arb (
        .clk   (clk),
        .clr_n (clr_n),
        .en    (arb_en),
        .req   ({b_req, a_req}),
        .gnt   (gnt)
    );

    assign a_gnt = gnt[0];
    assign b_gnt = gnt[1];

    // Mux the granted requester's fields onto the single bank port.
    always_comb begin
        sel_src   = gnt[1] ? SRC_B : SRC_A;
        sel_we    = gnt[1] ? b_we    : a_we;
        sel_addr  = gnt[1] ? b_addr  : a_addr;
        sel_wdata = gnt[1] ? b_wdata : a_wdata;
        do_xfer   = gnt[0] | gnt[1];
    end

    // FSM state register and sweep index.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= ST_RUN;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: a clear request starts the sweep; the sweep ends once the
    // last register has been zeroed, leaving the index back at 0.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_RUN: begin
                if (clear_all) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // FSM outputs: busy during the sweep; arbitration is suppressed during
    // the sweep and in the RUN cycle that launches it.
    always_comb begin
        busy      = (state_q == ST_CLEAR);
        arb_en    = (state_q == ST_RUN) && !clear_all;
        state_dbg = state_q;
    end

    // Bank storage: sweep zeroing or a granted write, never both.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < NREGS; i++) begin
                bank_q[i] <= '0;
            end
        end else if (state_q == ST_CLEAR) begin
            bank_q[idx_q] <= '0;
        end else if (do_xfer && sel_we) begin
            bank_q[sel_addr] <= sel_wdata;
        end
    end

    // Read path: capture data and source on a read grant; rdata holds
    // between reads, rvalid is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rsrc_q   <= SRC_A;
        end else begin
            rvalid_q <= do_xfer && !sel_we;
            if (do_xfer && !sel_we) begin
                rdata_q <= bank_q[sel_addr];
                rsrc_q  <= sel_src;
            end
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign rsrc   = rsrc_q;

endmodule : reg_bank_ctrl

// File: tb/tb_reg_bank_ctrl.sv
// Directed bench for reg_bank_ctrl: reset state, arbitration order,
// write/read paths, clear sweep and reset during a sweep.
module tb_reg_bank_ctrl;

    logic       clk;
    logic       clr_n;
    logic       a_req, a_we;
    logic [1:0] a_addr;
    logic [3:0] a_wdata;
    logic       a_gnt;
    logic       b_req, b_we;
    logic [1:0] b_addr;
    logic [3:0] b_wdata;
    logic       b_gnt;
    logic       clear_all;
    logic [3:0] rdata;
    logic       rvalid, rsrc, busy, state_dbg;

    int n_cmp;
    int n_err;

    reg_bank_ctrl dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .clear_all (clear_all),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rsrc      (rsrc),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net against a runaway run.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clr_n = 1'b0; clear_all = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = 2'd0; a_wdata = 4'h0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 2'd0; b_wdata = 4'h0;

        // 1: reset held 2 cycles, grants blocked while in reset
        tick();
        a_req = 1'b1; b_req = 1'b1;
        #1;
        chk("rst_a_gnt", a_gnt, 0);
        chk("rst_b_gnt", b_gnt, 0);
        tick();
        a_req = 1'b0; b_req = 1'b0;
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rsrc", rsrc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", state_dbg, 0);
        clr_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_req = 1'b1; a_we = 1'b0; a_addr = 2'(i);
            #1;
            chk("t1_a_gnt", a_gnt, 1);
            tick();
            a_req = 1'b0;
            chk("t1_rvalid", rvalid, 1);
            chk("t1_rdata", rdata, 0);
            chk("t1_rsrc", rsrc, 0);
            chk("t1_busy", busy, 0);
        end
        tick();
        chk("t1_rvalid_pulse", rvalid, 0);

        // 2: A writes 4'hA to addr 2, B reads it next cycle
        a_req = 1'b1; a_we = 1'b1; a_addr = 2'd2; a_wdata = 4'hA;
        #1;
        chk("t2_a_gnt", a_gnt, 1);
        chk("t2_b_gnt0", b_gnt, 0);
        tick();
        a_req = 1'b0;
        chk("t2_no_rvalid_on_write", rvalid, 0);
        b_req = 1'b1; b_we = 1'b0; b_addr = 2'd2;
        #1;
        chk("t2_b_gnt", b_gnt, 1);
        chk("t2_a_gnt0", a_gnt, 0);
        tick();
        b_req = 1'b0;
        chk("t2_rvalid", rvalid, 1);
        chk("t2_rdata", rdata, 4'hA);
        chk("t2_rsrc", rsrc, 1);
        tick();
        chk("t2_rvalid_drop", rvalid, 0);
        chk("t2_rdata_hold", rdata, 4'hA);
        chk("t2_rsrc_hold", rsrc, 1);

        // 3: from reset, both request for 4 cycles -> A,B,A,B
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 2'd0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 2'd1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_a_gnt", a_gnt, (k % 2 == 0) ? 1 : 0);
            chk("t3_b_gnt", b_gnt, (k % 2 == 0) ? 0 : 1);
            chk("t3_onehot", a_gnt & b_gnt, 0);
            tick();
            chk("t3_rvalid", rvalid, 1);
            chk("t3_rsrc", rsrc, (k % 2 == 0) ? 0 : 1);
        end
        a_req = 1'b0; b_req = 1'b0;
        // idle cycle must not move the pointer: last grant was B, so A wins
        tick();
        a_req = 1'b1; b_req = 1'b1;
        #1;
        chk("t3_idle_a_gnt", a_gnt, 1);
        tick();
        a_req = 1'b0; b_req = 1'b0;

        // 4: fill with 4'h5, then clear_all with a pending A request
        for (int i = 0; i < 4; i++) begin
            a_req = 1'b1; a_we = 1'b1; a_addr = 2'(i); a_wdata = 4'h5;
            tick();
        end
        a_we = 1'b0; a_addr = 2'd3;
        tick();
        a_req = 1'b0;
        chk("t4_pre_rdata", rdata, 4'h5);
        a_req = 1'b1; a_we = 1'b0; a_addr = 2'd0;
        clear_all = 1'b1;
        #1;
        chk("t4_no_gnt_on_clear", a_gnt, 0);
        tick();
        clear_all = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t4_busy", busy, 1);
            chk("t4_gnt_blocked", a_gnt, 0);
            tick();
        end
        chk("t4_busy_drop", busy, 0);
        chk("t4_gnt_after", a_gnt, 1);
        tick();
        chk("t4_rvalid0", rvalid, 1);
        chk("t4_rdata0", rdata, 0);
        for (int i = 1; i < 4; i++) begin
            a_addr = 2'(i);
            tick();
            chk("t4_rdata", rdata, 0);
        end
        a_req = 1'b0;

        // 5: reset while sweep at idx 2
        a_req = 1'b1; a_we = 1'b1; a_addr = 2'd3; a_wdata = 4'h7;
        tick();
        a_req = 1'b0;
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        tick();
        tick();
        chk("t5_busy_mid", busy, 1);
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        chk("t5_busy_after_rst", busy, 0);
        chk("t5_state_run", state_dbg, 0);
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t5_busy", busy, 1);
            tick();
        end
        chk("t5_busy_end", busy, 0);

        // 6: write 4'h3 to addr 1, read it back the very next cycle
        a_req = 1'b1; a_we = 1'b1; a_addr = 2'd1; a_wdata = 4'h3;
        #1;
        chk("t6_wr_gnt", a_gnt, 1);
        tick();
        a_we = 1'b0;
        #1;
        chk("t6_rd_gnt", a_gnt, 1);
        tick();
        a_req = 1'b0;
        chk("t6_rvalid", rvalid, 1);
        chk("t6_rdata", rdata, 4'h3);
        chk("t6_rsrc", rsrc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_reg_bank_ctrl
